// File: rtl/otter_cu_fsm_pkg.sv
// Shared types and constants for the OTTER control-unit sequencer.
package otter_pkg;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_RG3    = 7'b0110011,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR
   } cu_state_t;

   localparam logic [2:0] F3_MRET = 3'b000;

   // State taken at an instruction boundary.
   function automatic cu_state_t boundary_next(input logic int_pend, input logic csr_mie);
      return (int_pend && csr_mie) ? ST_INTR : ST_FETCH;
   endfunction

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Memory strobe/ready bundle between the control unit and instruction/data memory.
interface otter_cu_fsm_if;
   logic mem_rden1;
   logic mem_rden2;
   logic mem_we2;
   logic mem_rdy;

   modport master (output mem_rden1, output mem_rden2, output mem_we2, input mem_rdy);
   modport slave  (input mem_rden1, input mem_rden2, input mem_we2, output mem_rdy);
endinterface

// File: rtl/otter_cu_fsm_intr_sync.sv
// Interrupt input synchronizer, rising-edge detector and sticky pending flag.
module otter_intr_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic intr,
   input  logic clr,
   output logic int_pend
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   rise;

   assign rise = sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync     <= '0;
         int_pend <= 1'b0;
      end else begin
         sync     <= {sync[SYNC_STAGES-2:0], intr};
         // A fresh edge wins over the clear so it is not lost during entry.
         int_pend <= rise | (int_pend & ~clr);
      end
   end

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle sequencer for the OTTER CPU: fetch/exec/writeback, interrupt entry, load timeout.
module otter_cu_fsm
   import otter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  intr,
   input  logic [6:0]            opcode,
   input  logic [2:0]            func3,
   input  logic                  csr_mie,
   otter_cu_fsm_if.master        mem,
   output logic                  pc_rst,
   output logic                  pc_write,
   output logic                  reg_write,
   output logic                  csr_we,
   output logic                  int_taken,
   output logic                  mret_exec,
   output logic                  illegal_op,
   output logic                  bus_err
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   cu_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             int_pend;
   logic             timeout;

   otter_intr_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_intr_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .intr     (intr),
      .clr      (state == ST_INTR),
      .int_pend (int_pend)
   );

   assign timeout = (cnt == CNT_W'(MEM_TIMEOUT - 1)) && !mem.mem_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
         cnt   <= '0;
      end else begin
         case (state)
            ST_INIT:  state <= ST_FETCH;
            ST_FETCH: state <= ST_EXEC;
            ST_EXEC: begin
               if (opcode == OP_LOAD) begin
                  state <= ST_WB;
                  cnt   <= '0;
               end else begin
                  state <= boundary_next(int_pend, csr_mie);
               end
            end
            ST_WB: begin
               if (mem.mem_rdy || timeout) state <= boundary_next(int_pend, csr_mie);
               else                        cnt   <= cnt + CNT_W'(1);
            end
            ST_INTR:  state <= ST_FETCH;
            default:  state <= ST_INIT;
         endcase
      end
   end

   // Strobes decode from the current state; everything is held low during reset.
   always_comb begin
      pc_rst        = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      mem.mem_rden1 = 1'b0;
      mem.mem_rden2 = 1'b0;
      mem.mem_we2   = 1'b0;
      csr_we        = 1'b0;
      int_taken     = 1'b0;
      mret_exec     = 1'b0;
      illegal_op    = 1'b0;
      bus_err       = 1'b0;
      if (rst_n) begin
         case (state)
            ST_INIT:  pc_rst        = 1'b1;
            ST_FETCH: mem.mem_rden1 = 1'b1;
            ST_EXEC: begin
               case (opcode)
                  OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
                     pc_write  = 1'b1;
                     reg_write = 1'b1;
                  end
                  OP_BRANCH: pc_write = 1'b1;
                  OP_STORE: begin
                     pc_write    = 1'b1;
                     mem.mem_we2 = 1'b1;
                  end
                  OP_LOAD: mem.mem_rden2 = 1'b1;
                  OP_SYSTEM: begin
                     pc_write = 1'b1;
                     if (func3 == F3_MRET) begin
                        mret_exec = 1'b1;
                     end else begin
                        csr_we    = 1'b1;
                        reg_write = 1'b1;
                     end
                  end
                  default: begin
                     pc_write   = 1'b1;
                     illegal_op = 1'b1;
                  end
               endcase
            end
            ST_WB: begin
               mem.mem_rden2 = 1'b1;
               if (mem.mem_rdy) begin
                  reg_write = 1'b1;
                  pc_write  = 1'b1;
               end else if (timeout) begin
                  bus_err  = 1'b1;
                  pc_write = 1'b1;
               end
            end
            ST_INTR: begin
               int_taken = 1'b1;
               pc_write  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Sequencing half of the OTTER control unit; pairs with the combinational decoder (CU_DCDR).
- The decoder selects datapath sources. This block decides when state changes: PC write, register-file write, memory read/write strobes, CSR write.
- Also handles interrupt entry and bus timeouts.
- Multicycle flow: FETCH -> EXEC -> (WB) -> (INTR) -> FETCH. Consumes ir[6:0] and ir[14:12] from the instruction memory output.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous intr input (legal range 2..4).
- MEM_TIMEOUT, 15, maximum cycles spent waiting in WB for mem_rdy before declaring a bus error (legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- intr  in  1  external interrupt request; asynchronous; rising edge is significant.
- opcode  in  7  ir[6:0].
- func3  in  3  ir[14:12].
- csr_mie  in  1  machine interrupt enable from the CSR file.
- mem_rdy  in  1  data-memory read data valid.
- pc_rst  out  1  forces PC to reset vector.
- pc_write  out  1  PC register enable.
- reg_write  out  1  register-file write enable.
- mem_rden1  out  1  instruction-memory read.
- mem_rden2  out  1  data-memory read.
- mem_we2  out  1  data-memory write.
- csr_we  out  1  CSR write enable.
- int_taken  out  1  interrupt entry; PC source = mtvec, mepc/mie updates.
- mret_exec  out  1  MRET executing; PC source = mepc.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.
- bus_err  out  1  one-cycle pulse on a load timeout.

Behaviour:
- Reset (rst_n low, async): state=ST_INIT, int_pend=0, sync chain=0, timeout counter=0. All outputs 0 while rst_n low.
- Outputs are combinational from state, plus opcode/func3 in ST_EXEC. Every output defaults to 0 in every state.
- ST_INIT: pc_rst=1. Lasts one cycle after rst_n deasserts, then goes to ST_FETCH.
- ST_FETCH: mem_rden1=1. Next state ST_EXEC; the synchronous IMEM presents the instruction in EXEC.
- ST_EXEC, by opcode:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP_IMM 0010011, OP_RG3 0110011: pc_write=1, reg_write=1.
  - BRANCH 1100011: pc_write=1 only; the decoder supplies the target.
  - STORE 0100011: pc_write=1, mem_we2=1.
  - LOAD 0000011: mem_rden2=1, pc_write=0. Next state ST_WB; counter cleared.
  - SYSTEM 1110011, func3=000: mret_exec=1, pc_write=1.
  - SYSTEM 1110011, func3!=000: csr_we=1, reg_write=1, pc_write=1.
  - Any other opcode: pc_write=1, illegal_op=1; otherwise executes as a NOP.
  - Every non-LOAD instruction then goes to ST_INTR if (int_pend & csr_mie), else ST_FETCH.
  - MRET samples csr_mie in the same cycle. The CSR file updates MIE on the following edge, so the pre-MRET value governs.
- ST_WB:
  - mem_rden2 is held at 1.
  - If mem_rdy=1: reg_write=1, pc_write=1, then the interrupt check as in EXEC.
  - Else the counter increments. When the counter reaches MEM_TIMEOUT-1 with mem_rdy still 0: bus_err=1, pc_write=1, reg_write=0, then the interrupt check.
  - mem_rdy=1 in the timeout cycle counts as success; no bus_err.
- ST_INTR: int_taken=1, pc_write=1. Clears int_pend. Next state ST_FETCH. Exactly one cycle.
- Interrupt path:
  - intr passes through SYNC_STAGES flops, then an edge detector on the last two stages.
  - A rising edge sets the sticky int_pend.
  - Set and clear in the same cycle: set wins, so a new edge arriving during ST_INTR stays pending.
  - Level-held intr does not retrigger.
  - Interrupts are checked only at instruction boundaries (end of EXEC or WB); never mid-instruction.
- csr_mie=0: int_pend is retained and serviced at the first boundary after csr_mie=1.
- Reset mid-load: returns to ST_INIT immediately; no reg_write is issued; int_pend is lost.
- Counter width: ceil(log2(MEM_TIMEOUT+1)) bits; it never wraps because it is cleared on WB entry.

Decomposition:
- Package otter_pkg holds:
  - opcode_t enum (the nine RV32I opcodes plus SYSTEM=7'b1110011);
  - cu_state_t enum {ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR};
  - constant F3_MRET=3'b000.
- Sub-module otter_intr_sync (params SYNC_STAGES; ports clk, rst_n, intr, clr, int_pend) holds the synchronizer, edge detector and sticky latch.
- The FSM and timeout counter stay in otter_cu_fsm.

Test Plan:
- Release rst_n, opcode=0010011 -> cycle 1: pc_rst=1; cycle 2: mem_rden1=1; cycle 3: pc_write=1, reg_write=1; cycle 4: mem_rden1=1.
- LOAD, mem_rdy low for 3 WB cycles then high -> mem_rden2=1 for 5 cycles (EXEC plus 4 WB); reg_write=pc_write=1 only in the 4th WB cycle; bus_err=0.
- LOAD, mem_rdy held 0, MEM_TIMEOUT=15 -> bus_err pulses in the 15th WB cycle; reg_write never asserted; next state ST_FETCH.
- intr rising edge during the EXEC of an ADDI, csr_mie=1 -> int_pend set after 3 clocks. The next instruction boundary goes to ST_INTR: int_taken=1 for exactly one cycle; intr held high afterwards causes no second entry.
- Edge with csr_mie=0 for 3 instructions, then csr_mie=1 -> no INTR during the first 3 instructions; INTR after the first instruction completing with csr_mie=1.
- opcode=1110011 with func3=000 -> mret_exec=1, pc_write=1, csr_we=0. With func3=001 -> csr_we=1, reg_write=1. opcode=1111111 -> illegal_op=1 for one cycle, pc_write=1.
